// File: rtl/xaui_pkg.sv
// Shared XAUI definitions: lane/byte counts and the link sequencer state encoding.
package xaui_pkg;

  localparam int XAUI_LANES = 4;
  localparam int XAUI_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST       = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_ALIGN     = 3'd3,
    ST_BOND      = 3'd4,
    ST_UP        = 3'd5
  } seq_state_t;

endpackage

// File: rtl/xaui_link_sequencer_if.sv
// Control, MGT status/control and statistics bundle between a port owner (master) and its link sequencer (slave).
interface xaui_link_sequencer_if;
  import xaui_pkg::*;

  logic                    enable;
  logic                    clr_counts;
  logic [XAUI_LANES-1:0]   mgt_rxlock;
  logic [XAUI_LANES-1:0]   mgt_syncok;
  logic [XAUI_BYTES-1:0]   mgt_codevalid;
  logic [XAUI_LANES-1:0]   mgt_rxbufferr;
  logic [XAUI_LANES-1:0]   mgt_tx_reset;
  logic [XAUI_LANES-1:0]   mgt_rx_reset;
  logic [XAUI_LANES-1:0]   mgt_enable_align;
  logic                    mgt_enchansync;
  logic                    link_up;
  logic [2:0]              seq_state;
  logic [7:0]              retry_count;
  logic [15:0]             err_count;

  modport master (
    output enable, clr_counts, mgt_rxlock, mgt_syncok, mgt_codevalid, mgt_rxbufferr,
    input  mgt_tx_reset, mgt_rx_reset, mgt_enable_align, mgt_enchansync,
           link_up, seq_state, retry_count, err_count
  );

  modport slave (
    input  enable, clr_counts, mgt_rxlock, mgt_syncok, mgt_codevalid, mgt_rxbufferr,
    output mgt_tx_reset, mgt_rx_reset, mgt_enable_align, mgt_enchansync,
           link_up, seq_state, retry_count, err_count
  );

endinterface

// File: rtl/xaui_seq_timer.sv
// Single per-state cycle timer: cleared on state entry, counts up to limit-1 and holds there (never wraps).
module xaui_seq_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  // done marks the last cycle of a limit-cycle dwell
  assign done = (count_q == limit - W'(1));

  always_comb begin
    count_d = count_q;
    if (clear)      count_d = '0;
    else if (!done) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/xaui_link_sequencer.sv
// XAUI port bring-up/supervision FSM with retry/error statistics.
// Statistics counters exist only when XAUI_LINK_SEQ_STATS_EN is defined; otherwise they read 0.
module xaui_link_sequencer
  import xaui_pkg::*;
#(
  parameter int RESET_CYCLES = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int SYNC_TIMEOUT = 4096,
  parameter int BOND_CYCLES  = 256,
  parameter int ERR_THRESH   = 16
) (
  input  logic                 mgt_clk,
  input  logic                 reset,
  xaui_link_sequencer_if.slave bus
);

  localparam int TMAX01 = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX23 = (SYNC_TIMEOUT > BOND_CYCLES) ? SYNC_TIMEOUT : BOND_CYCLES;
  localparam int TMAX   = (TMAX01 > TMAX23) ? TMAX01 : TMAX23;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int CW     = $clog2(ERR_THRESH + 1);

  seq_state_t          state_q, state_d;
  logic [TW-1:0]       limit;
  logic                timer_done;
  logic                retry_inc;
  logic                err_cycle, up_err, consec_hit;
  logic [CW-1:0]       consec_q, consec_d;
  logic [3:0]          tx_reset_q, rx_reset_q, align_q;
  logic                chansync_q, link_up_q;

  assign err_cycle  = (bus.mgt_codevalid != 8'hFF) || (|bus.mgt_rxbufferr);
  assign up_err     = (state_q == ST_UP) && err_cycle;
  assign consec_hit = up_err && ((int'(consec_q) + 1) >= ERR_THRESH);

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    limit     = TW'(RESET_CYCLES);
    case (state_q)
      ST_IDLE: if (bus.enable) state_d = ST_RST;
      ST_RST: begin
        limit = TW'(RESET_CYCLES);
        if (timer_done) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        limit = TW'(LOCK_TIMEOUT);
        if (bus.mgt_rxlock == 4'hF) state_d = ST_ALIGN;
        else if (timer_done) begin
          state_d   = ST_RST;
          retry_inc = 1'b1;
        end
      end
      ST_ALIGN: begin
        limit = TW'(SYNC_TIMEOUT);
        if (bus.mgt_syncok == 4'hF) state_d = ST_BOND;
        else if (timer_done) begin
          state_d   = ST_RST;
          retry_inc = 1'b1;
        end
      end
      ST_BOND: begin
        limit = TW'(BOND_CYCLES);
        if (timer_done) begin
          if (bus.mgt_syncok == 4'hF) state_d = ST_UP;
          else begin
            state_d   = ST_RST;
            retry_inc = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (bus.mgt_rxlock != 4'hF || consec_hit) begin
          state_d   = ST_RST;
          retry_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Dropping enable overrides everything and is not a retry
    if (!bus.enable) begin
      state_d   = ST_IDLE;
      retry_inc = 1'b0;
    end
  end

  always_comb begin
    consec_d = '0;
    if (up_err && state_d == ST_UP) consec_d = consec_q + CW'(1);
  end

  xaui_seq_timer #(.W(TW)) u_timer (
    .clk   (mgt_clk),
    .rst   (reset),
    .clear (state_d != state_q),
    .limit (limit),
    .done  (timer_done)
  );

  // Outputs are registered from the next state so they track seq_state exactly
  always_ff @(posedge mgt_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      consec_q   <= '0;
      tx_reset_q <= 4'hF;
      rx_reset_q <= 4'hF;
      align_q    <= 4'h0;
      chansync_q <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      consec_q   <= consec_d;
      tx_reset_q <= (state_d == ST_IDLE || state_d == ST_RST) ? 4'hF : 4'h0;
      rx_reset_q <= (state_d == ST_IDLE || state_d == ST_RST) ? 4'hF : 4'h0;
      align_q    <= (state_d == ST_ALIGN || state_d == ST_BOND || state_d == ST_UP) ? 4'hF : 4'h0;
      chansync_q <= (state_d == ST_BOND || state_d == ST_UP);
      link_up_q  <= (state_d == ST_UP);
    end
  end

`ifdef XAUI_LINK_SEQ_STATS_EN
  logic [7:0]  retry_q;
  logic [15:0] err_q;

  // Clear wins over a same-cycle increment; both counters saturate
  always_ff @(posedge mgt_clk or posedge reset) begin
    if (reset) begin
      retry_q <= '0;
      err_q   <= '0;
    end else if (bus.clr_counts) begin
      retry_q <= '0;
      err_q   <= '0;
    end else begin
      if (retry_inc && retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
      if (up_err && err_q != 16'hFFFF)   err_q   <= err_q + 16'd1;
    end
  end

  assign bus.retry_count = retry_q;
  assign bus.err_count   = err_q;
`else
  assign bus.retry_count = 8'h00;
  assign bus.err_count   = 16'h0000;
`endif

  assign bus.seq_state        = state_q;
  assign bus.mgt_tx_reset     = tx_reset_q;
  assign bus.mgt_rx_reset     = rx_reset_q;
  assign bus.mgt_enable_align = align_q;
  assign bus.mgt_enchansync   = chansync_q;
  assign bus.link_up          = link_up_q;

endmodule
